if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes occur on the rising edge.
REQ-003 SHALL have port clrn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port stall, input, 1 bit: 1 holds the PC and the IF/ID outputs (hazard unit).
REQ-005 SHALL have port pcsrc, input, 2 bits: next-PC select; 00 = pc+4, 01 = bpc, 10 = jpc, 11 = rpc.
REQ-006 SHALL have ports bpc, jpc and rpc, input, 32 bits each: branch, jump and register targets.
REQ-007 SHALL have ports imem_req (output, 1 bit) and imem_addr (output, 32 bits): the fetch request and its address.
REQ-008 SHALL have ports imem_ready (input, 1 bit) and imem_rdata (input, 32 bits): the fetch-complete strobe and the instruction word, valid in the same cycle.
REQ-009 SHALL have output port pc, 32 bits: the current fetch address.
REQ-010 SHALL have output ports id_inst (32 bits), id_pc4 (32 bits) and id_valid (1 bit): the IF/ID pipeline register.

Function
REQ-011 SHALL implement three states: FETCH (request outstanding), HOLD (word buffered, stalled) and DRAIN (one idle cycle after the buffer releases).
REQ-012 SHALL drive imem_req=1 and imem_addr=pc in FETCH; imem_addr SHALL stay stable until imem_ready=1.
REQ-013 SHALL treat a fetch as complete in any cycle with imem_req=1 and imem_ready=1.
REQ-014 SHALL select npc combinationally from pcsrc in the cycle the PC updates (delay-slot semantics: a redirect applies to the fetch after the current one).
REQ-015 SHALL, on fetch complete with stall=0: set id_inst<=imem_rdata, id_pc4<=pc+4, id_valid<=1 and pc<=npc, and remain in FETCH.
REQ-016 SHALL, on fetch complete with stall=1: capture imem_rdata and pc+4 into the hold buffer, keep pc, keep IF/ID unchanged, and enter HOLD.
REQ-017 SHALL, in HOLD, drive imem_req=0 and ignore imem_ready.
REQ-018 SHALL, in HOLD with stall=0: load IF/ID from the hold buffer (id_valid<=1), set pc<=npc, and enter DRAIN.
REQ-019 SHALL, in DRAIN, drive imem_req=0 and return to FETCH in the next cycle.
REQ-020 SHALL, in any cycle with stall=0 and no word delivered, load a bubble: id_valid<=0, id_inst<=32'h0; id_pc4 SHALL be held.
REQ-021 SHALL hold id_inst, id_pc4 and id_valid unchanged in any cycle with stall=1.
REQ-022 SHALL compute pc+4 modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0) and SHALL pass all targets unmodified, including unaligned low bits.

Reset
REQ-023 SHALL, while clrn=0, force pc=RESET_PC, id_inst=0, id_pc4=0, id_valid=0, hold buffer=0, state=FETCH and imem_req=0, independently of clk.
REQ-024 SHALL drop an outstanding fetch on reset mid-request; the first rising edge after clrn=1 SHALL start a fresh request at RESET_PC.

Configuration
REQ-025 SHALL, with macro FETCH_PERF_EN defined, add 32-bit outputs perf_fetch (count of completed fetches) and perf_stall (count of cycles with stall=1); both SHALL reset to 0 and wrap at 2^32.
REQ-026 SHALL, without FETCH_PERF_EN, omit these ports and counters, with all other behaviour identical.

Verification
REQ-027 Reset: clrn low mid-request with RESET_PC=32'h0000_0100 -> pc=0x100, id_valid=0, imem_req=0; after release, imem_addr=0x100.
REQ-028 Sequential fetch: imem_ready=1 every cycle, rdata=0x11,0x22,0x33 -> id_inst 0x11,0x22,0x33 with id_pc4 0x104,0x108,0x10C.
REQ-029 Redirect: pcsrc=01, bpc=0x2000 at completion of fetch 0x104 -> next imem_addr=0x2000, id_pc4=0x108.
REQ-030 Stall: stall=1 on completion of 0x0A at 0x108 -> HOLD, imem_req=0 for 3 stall cycles; release -> id_inst=0x0A, DRAIN, then fetch at 0x10C.
REQ-031 Memory wait: imem_ready low 4 cycles -> imem_addr stable, id_valid=0 for 4 cycles; PC wraps from 0xFFFF_FFFC to 0x0.
REQ-032 With FETCH_PERF_EN: 5 completed fetches and 3 stall cycles -> perf_fetch=5, perf_stall=3.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, memory request handshake and IF/ID register,
// with a one-word hold buffer for stalls. Define FETCH_PERF_EN to add fetch/stall counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] rpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
`ifdef FETCH_PERF_EN
    output logic        id_valid,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
`else
    output logic        id_valid
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_pc;
    logic [31:0] r_idInst;
    logic [31:0] r_idPc4;
    logic        r_idValid;
    logic [31:0] r_holdInst;
    logic [31:0] r_holdPc4;

    logic [31:0] w_pc4;
    logic [31:0] w_npc;
    logic        w_fetchDone;

    assign w_pc4       = r_pc + 32'd4;
    assign w_fetchDone = r_req & imem_ready;

    // Redirects select the PC of the fetch after the one completing now.
    always_comb begin
        w_npc = w_pc4;
        case (pcsrc)
            2'b01:   w_npc = bpc;
            2'b10:   w_npc = jpc;
            2'b11:   w_npc = rpc;
            default: w_npc = w_pc4;
        endcase
    end

    // The request is registered, so the first cycle after reset release is idle
    // and the fresh request at RESET_PC appears after the first rising edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= FETCH;
            r_req      <= 1'b0;
            r_pc       <= RESET_PC;
            r_idInst   <= 32'h0;
            r_idPc4    <= 32'h0;
            r_idValid  <= 1'b0;
            r_holdInst <= 32'h0;
            r_holdPc4  <= 32'h0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_fetchDone && !stall) begin
                        r_idInst  <= imem_rdata;
                        r_idPc4   <= w_pc4;
                        r_idValid <= 1'b1;
                        r_pc      <= w_npc;
                        r_req     <= 1'b1;
                    end else if (w_fetchDone) begin
                        r_holdInst <= imem_rdata;
                        r_holdPc4  <= w_pc4;
                        r_req      <= 1'b0;
                        r_state    <= HOLD;
                    end else begin
                        r_req <= 1'b1;
                        if (!stall) begin
                            r_idInst  <= 32'h0;
                            r_idValid <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        r_idInst  <= r_holdInst;
                        r_idPc4   <= r_holdPc4;
                        r_idValid <= 1'b1;
                        r_pc      <= w_npc;
                        r_state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_req   <= 1'b1;
                    r_state <= FETCH;
                    if (!stall) begin
                        r_idInst  <= 32'h0;
                        r_idValid <= 1'b0;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign id_inst   = r_idInst;
    assign id_pc4    = r_idPc4;
    assign id_valid  = r_idValid;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perfFetch;
    logic [31:0] r_perfStall;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_perfFetch <= 32'h0;
            r_perfStall <= 32'h0;
        end else begin
            if (w_fetchDone) r_perfFetch <= r_perfFetch + 32'd1;
            if (stall)       r_perfStall <= r_perfStall + 32'd1;
        end
    end

    assign perf_fetch = r_perfFetch;
    assign perf_stall = r_perfStall;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed vector table, async reset sequence and
// randomized traffic against a queue-based reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        clrn;
    logic        stall;
    logic [1:0]  pcsrc;
    logic [31:0] bpc, jpc, rpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc, id_inst, id_pc4;
    logic        id_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .clrn(clrn), .stall(stall), .pcsrc(pcsrc),
        .bpc(bpc), .jpc(jpc), .rpc(rpc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc(pc), .id_inst(id_inst), .id_pc4(id_pc4),
`ifdef FETCH_PERF_EN
        .id_valid(id_valid), .perf_fetch(perf_fetch), .perf_stall(perf_stall)
`else
        .id_valid(id_valid)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        stall;
        logic [1:0]  pcsrc;
        logic        ready;
        logic [31:0] rdata;
        logic [31:0] bpc;
        logic [31:0] jpc;
        logic [31:0] rpc;
        logic        expReq;
        logic [31:0] expPc;
        logic [31:0] expInst;
        logic [31:0] expPc4;
        logic        expValid;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } held_t;

    // Reference model: a word fetched under stall waits in a queue until the stall
    // lifts; the cycle after it leaves is idle, then fetching resumes.
    logic [31:0] mPc, mInst, mPc4;
    logic        mValid, mReq;
    int unsigned mFetch, mStall;
    held_t       mHeld[$];

    task automatic modelReset();
        mPc = RST_PC; mInst = 0; mPc4 = 0; mValid = 0; mReq = 0;
        mFetch = 0; mStall = 0;
        mHeld.delete();
    endtask

    task automatic modelStep();
        logic [31:0] seqPc;
        logic [31:0] target;
        held_t h;
        seqPc  = mPc + 32'd4;
        target = (pcsrc == 2'd1) ? bpc : (pcsrc == 2'd2) ? jpc : (pcsrc == 2'd3) ? rpc : seqPc;
        if (stall) mStall++;
        if (mReq && imem_ready) begin
            mFetch++;
            if (!stall) begin
                mInst = imem_rdata; mPc4 = seqPc; mValid = 1; mPc = target;
            end else begin
                h.inst = imem_rdata; h.pc4 = seqPc;
                mHeld.push_back(h);
                mReq = 0;
            end
        end else if (mHeld.size() != 0) begin
            if (!stall) begin
                h = mHeld.pop_front();
                mInst = h.inst; mPc4 = h.pc4; mValid = 1; mPc = target;
            end
        end else begin
            mReq = 1;
            if (!stall) begin
                mInst = 0; mValid = 0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] src, input logic rdy,
                                 input logic [31:0] rd, input logic [31:0] b,
                                 input logic [31:0] j, input logic [31:0] r);
        @(negedge clk);
        stall = s; pcsrc = src; imem_ready = rdy; imem_rdata = rd;
        bpc = b; jpc = j; rpc = r;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{0, 2'd0, 0, 32'h0,  32'h0,    32'h0,         32'h0,    1, 32'h100,       32'h0,  32'h0,    0};
        vecs[1]  = '{0, 2'd0, 1, 32'h11, 32'h0,    32'h0,         32'h0,    1, 32'h104,       32'h11, 32'h104,  1};
        vecs[2]  = '{0, 2'd1, 1, 32'h22, 32'h2000, 32'h0,         32'h0,    1, 32'h2000,      32'h22, 32'h108,  1};
        vecs[3]  = '{0, 2'd0, 1, 32'h33, 32'h0,    32'h0,         32'h0,    1, 32'h2004,      32'h33, 32'h2004, 1};
        vecs[4]  = '{1, 2'd0, 1, 32'h0A, 32'h0,    32'h0,         32'h0,    0, 32'h2004,      32'h33, 32'h2004, 1};
        vecs[5]  = '{1, 2'd0, 1, 32'h55, 32'h0,    32'h0,         32'h0,    0, 32'h2004,      32'h33, 32'h2004, 1};
        vecs[6]  = '{1, 2'd0, 0, 32'h0,  32'h0,    32'h0,         32'h0,    0, 32'h2004,      32'h33, 32'h2004, 1};
        vecs[7]  = '{0, 2'd0, 0, 32'h0,  32'h0,    32'h0,         32'h0,    0, 32'h2008,      32'h0A, 32'h2008, 1};
        vecs[8]  = '{0, 2'd0, 1, 32'h99, 32'h0,    32'h0,         32'h0,    1, 32'h2008,      32'h0,  32'h2008, 0};
        vecs[9]  = '{0, 2'd0, 0, 32'h0,  32'h0,    32'h0,         32'h0,    1, 32'h2008,      32'h0,  32'h2008, 0};
        vecs[10] = '{0, 2'd0, 0, 32'h0,  32'h0,    32'h0,         32'h0,    1, 32'h2008,      32'h0,  32'h2008, 0};
        vecs[11] = '{0, 2'd0, 0, 32'h0,  32'h0,    32'h0,         32'h0,    1, 32'h2008,      32'h0,  32'h2008, 0};
        vecs[12] = '{0, 2'd0, 0, 32'h0,  32'h0,    32'h0,         32'h0,    1, 32'h2008,      32'h0,  32'h2008, 0};
        vecs[13] = '{0, 2'd2, 1, 32'h44, 32'h0,    32'hFFFF_FFFC, 32'h0,    1, 32'hFFFF_FFFC, 32'h44, 32'h200C, 1};
        vecs[14] = '{0, 2'd0, 1, 32'h66, 32'h0,    32'h0,         32'h0,    1, 32'h0,         32'h66, 32'h0,    1};
        vecs[15] = '{0, 2'd3, 1, 32'h77, 32'h0,    32'h0,         32'h1233, 1, 32'h1233,      32'h77, 32'h4,    1};
        vecs[16] = '{0, 2'd0, 1, 32'h88, 32'h0,    32'h0,         32'h0,    1, 32'h1237,      32'h88, 32'h1237, 1};
        vecs[17] = '{1, 2'd0, 0, 32'h0,  32'h0,    32'h0,         32'h0,    1, 32'h1237,      32'h88, 32'h1237, 1};

        clrn = 0; stall = 0; pcsrc = 0; imem_ready = 0; imem_rdata = 0;
        bpc = 0; jpc = 0; rpc = 0;

        // Reset state while clrn is held low across clock edges
        @(negedge clk); @(negedge clk);
        checkOutput("rst_pc", pc, RST_PC);
        checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
        checkOutput("rst_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("rst_inst", id_inst, 32'h0);
        checkOutput("rst_pc4", id_pc4, 32'h0);
        clrn = 1;
        @(posedge clk); #1;
        checkOutput("rel_req", {31'h0, imem_req}, 32'h1);
        applyStimulus(0, 2'd0, 1, 32'hDEAD, 0, 0, 0);
        checkOutput("pre_pc", pc, 32'h104);

        // Asynchronous reset in the middle of an outstanding request
        @(negedge clk);
        imem_ready = 0;
        #2 clrn = 0;
        #1;
        checkOutput("mid_rst_pc", pc, RST_PC);
        checkOutput("mid_rst_req", {31'h0, imem_req}, 32'h0);
        checkOutput("mid_rst_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("mid_rst_inst", id_inst, 32'h0);
        @(negedge clk);
        clrn = 1;
        @(posedge clk); #1;
        checkOutput("mid_rel_req", {31'h0, imem_req}, 32'h1);
        checkOutput("mid_rel_addr", imem_addr, RST_PC);

        // Directed table: sequential, redirect, stall/hold/drain, wait, wrap, unaligned
        modelReset();
        @(negedge clk); clrn = 0;
        @(negedge clk); clrn = 1;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].pcsrc, vecs[i].ready, vecs[i].rdata,
                          vecs[i].bpc, vecs[i].jpc, vecs[i].rpc);
            checkOutput($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].expReq});
            checkOutput($sformatf("v%0d_addr", i), imem_addr, vecs[i].expPc);
            checkOutput($sformatf("v%0d_pc", i), pc, vecs[i].expPc);
            checkOutput($sformatf("v%0d_inst", i), id_inst, vecs[i].expInst);
            checkOutput($sformatf("v%0d_pc4", i), id_pc4, vecs[i].expPc4);
            checkOutput($sformatf("v%0d_valid", i), {31'h0, id_valid}, {31'h0, vecs[i].expValid});
        end
`ifdef FETCH_PERF_EN
        checkOutput("perf_fetch_tbl", perf_fetch, 32'd8);
        checkOutput("perf_stall_tbl", perf_stall, 32'd4);
`endif

        // Randomized traffic against the reference model
        @(negedge clk); clrn = 0; stall = 0; imem_ready = 0;
        modelReset();
        @(negedge clk); clrn = 1;
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(3) == 0), 2'($urandom_range(3)),
                          ($urandom_range(4) < 3), $urandom, $urandom, $urandom, $urandom);
            modelStep();
            checkOutput("rnd_req", {31'h0, imem_req}, {31'h0, mReq});
            checkOutput("rnd_addr", imem_addr, mPc);
            checkOutput("rnd_pc", pc, mPc);
            checkOutput("rnd_inst", id_inst, mInst);
            checkOutput("rnd_pc4", id_pc4, mPc4);
            checkOutput("rnd_valid", {31'h0, id_valid}, {31'h0, mValid});
`ifdef FETCH_PERF_EN
            checkOutput("rnd_perf_fetch", perf_fetch, mFetch);
            checkOutput("rnd_perf_stall", perf_stall, mStall);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
